fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of one FIFO instance (f_in/WR_EN) among N_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/rr_picker.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants and elaboration-time helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    localparam int N_REQ_MIN     = 2;
    localparam int N_REQ_MAX     = 8;
    localparam int BURST_LEN_MIN = 1;
    localparam int BURST_LEN_MAX = 15;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic bit params_ok(input int n_req, input int burst_len);
        return (n_req >= N_REQ_MIN) && (n_req <= N_REQ_MAX) &&
               (burst_len >= BURST_LEN_MIN) && (burst_len <= BURST_LEN_MAX);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first valid requester strictly after 'last', wrapping around.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] pick_oh,
    output logic [IDX_W-1:0] pick_idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = IDX_W'((int'(last) + off) % N_REQ);
            if (!found && req_valid[cand]) begin
                found         = 1'b1;
                pick_idx      = cand;
                pick_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among N_REQ valid/ready producers with
// round-robin grants, each grant holding the port for up to BURST_LEN words.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int f_WIDTH   = 8,
    parameter int N_REQ     = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                     clk,
    input  logic                     asyn_rst,
    input  logic                     arb_en,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*f_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     f_full,
    output logic [f_WIDTH-1:0]       f_in,
    output logic                     WR_EN,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy
);

    localparam int BEAT_W = clog2(BURST_LEN + 1);
    localparam int LAST_W = clog2(N_REQ);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_LEN);
    localparam logic [LAST_W-1:0] LAST_RESET = LAST_W'(N_REQ - 1);

    if (!params_ok(N_REQ, BURST_LEN)) begin : g_bad_params
        $error("fifo_wr_arbiter: N_REQ must be 2..8 and BURST_LEN 1..15");
    end

    logic              state_q,    state_d;
    logic [N_REQ-1:0]  grant_q,    grant_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LAST_W-1:0] last_q,     last_d;

    logic [N_REQ-1:0]  pick_oh;
    logic [LAST_W-1:0] pick_idx;
    logic              pick_found;
    logic [N_REQ-1:0]  accept_vec;
    logic [LAST_W-1:0] owner_idx;
    logic              owner_valid;
    logic [BEAT_W-1:0] beat_inc;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (LAST_W)
    ) u_picker (
        .req_valid (req_valid),
        .last      (last_q),
        .pick_oh   (pick_oh),
        .pick_idx  (pick_idx),
        .found     (pick_found)
    );

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = LAST_W'(i);
            end
        end
    end

    assign owner_valid = |(req_valid & grant_q);
    assign beat_inc    = beat_cnt_q + BEAT_W'(1);

    // Ready is masked by reset so the write port goes quiet the instant reset asserts.
    always_comb begin
        req_ready = '0;
        if (asyn_rst && !f_full) begin
            if (state_q == ST_BURST) begin
                req_ready = grant_q;
            end else if (arb_en && pick_found) begin
                req_ready = pick_oh;
            end
        end
    end

    assign accept_vec = req_valid & req_ready;
    assign WR_EN      = |accept_vec;

    always_comb begin
        f_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept_vec[i]) begin
                f_in = req_data[i*f_WIDTH +: f_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        last_d     = last_q;
        if (state_q == ST_IDLE) begin
            grant_d = '0;
            if (WR_EN) begin
                grant_d    = pick_oh;
                beat_cnt_d = BEAT_W'(1);
                if (BURST_LEN == 1) begin
                    last_d = pick_idx;
                end else begin
                    state_d = ST_BURST;
                end
            end
        end else if (!f_full) begin
            // A full FIFO freezes the burst; otherwise the owner either writes or releases.
            if (owner_valid) begin
                beat_cnt_d = beat_inc;
                if (beat_inc == BEAT_LAST) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    beat_cnt_d = '0;
                    last_d     = owner_idx;
                end
            end else begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                beat_cnt_d = '0;
                last_d     = owner_idx;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge asyn_rst) begin
        if (!asyn_rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            last_q     <= LAST_RESET;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            last_q     <= last_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a turn-based reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int BL = 4;

    logic           clk = 1'b0;
    logic           asyn_rst;
    logic           arb_en;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           f_full;
    logic [W-1:0]   f_in;
    logic           WR_EN;
    logic [N-1:0]   grant;
    logic           busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who owns the port (-1 = nobody), words taken this turn, last owner served.
    int m_owner;
    int m_words;
    int m_last;

    logic [W-1:0] wr_log[$];
    logic [N-1:0] grant_log[$];

    fifo_wr_arbiter #(
        .f_WIDTH   (W),
        .N_REQ     (N),
        .BURST_LEN (BL)
    ) dut (
        .clk       (clk),
        .asyn_rst  (asyn_rst),
        .arb_en    (arb_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .f_full    (f_full),
        .f_in      (f_in),
        .WR_EN     (WR_EN),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called just after a falling edge with inputs already driven; checks this cycle, advances the model.
    task automatic cycle();
        int           pick;
        logic [N-1:0] e_ready;
        logic [N-1:0] e_grant;
        logic [W-1:0] e_data;
        logic         e_wr;
        #1;
        if (!asyn_rst) begin
            m_owner = -1;
            m_words = 0;
            m_last  = N - 1;
        end
        e_ready = '0;
        pick    = -1;
        if (asyn_rst) begin
            if (m_owner < 0) begin
                if (arb_en && !f_full) begin
                    for (int k = 1; k <= N; k++) begin
                        if (pick < 0 && req_valid[(m_last + k) % N]) pick = (m_last + k) % N;
                    end
                    if (pick >= 0) e_ready[pick] = 1'b1;
                end
            end else if (!f_full) begin
                e_ready[m_owner] = 1'b1;
            end
        end
        e_wr   = |(e_ready & req_valid);
        e_data = '0;
        for (int i = 0; i < N; i++) begin
            if (e_ready[i] && req_valid[i]) e_data = req_data[i*W +: W];
        end
        e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;

        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("WR_EN", 32'(WR_EN), 32'(e_wr));
        check("f_in", 32'(f_in), 32'(e_data));
        check("grant", 32'(grant), 32'(e_grant));
        check("busy", 32'(busy), 32'(m_owner >= 0));

        if (WR_EN === 1'b1) wr_log.push_back(f_in);
        if (grant !== '0 && (grant_log.size() == 0 || grant_log[grant_log.size()-1] !== grant))
            grant_log.push_back(grant);

        if (asyn_rst) begin
            if (m_owner < 0) begin
                if (e_wr) begin
                    m_owner = pick;
                    m_words = 1;
                end
            end else if (!f_full) begin
                if (req_valid[m_owner]) begin
                    m_words++;
                    if (m_words == BL) begin
                        m_last  = m_owner;
                        m_owner = -1;
                    end
                end else begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        asyn_rst = 1'b0;
        repeat (2) cycle();
        asyn_rst = 1'b1;
        wr_log.delete();
        grant_log.delete();
    endtask

    initial begin
        asyn_rst  = 1'b0;
        arb_en    = 1'b1;
        req_valid = '0;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        f_full    = 1'b0;
        m_owner   = -1;
        m_words   = 0;
        m_last    = N - 1;
        @(negedge clk);

        // 1: two requesters alternate whole bursts, starting with req0.
        do_reset();
        req_valid = 4'b0101;
        repeat (12) cycle();
        check("t1_write_count", 32'(wr_log.size()), 32'd12);
        for (int i = 0; i < 12 && i < wr_log.size(); i++)
            check("t1_write_data", 32'(wr_log[i]), (i / 4 == 1) ? 32'h33 : 32'h11);

        // 2: all valid, grants rotate with no dead cycle.
        do_reset();
        req_valid = 4'b1111;
        repeat (20) cycle();
        check("t2_write_count", 32'(wr_log.size()), 32'd20);
        check("t2_grant_count", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check("t2_grant_seq", 32'(grant_log[i]), 32'(1 << (i % 4)));

        // 3: short burst released by a gap, then a fresh full burst.
        do_reset();
        req_valid = 4'b0010;
        req_data  = {8'h44, 8'h33, 8'haa, 8'h11};
        cycle();
        req_data  = {8'h44, 8'h33, 8'hbb, 8'h11};
        cycle();
        req_valid = 4'b0000;
        repeat (2) cycle();
        req_valid = 4'b0010;
        req_data  = {8'h44, 8'h33, 8'hcc, 8'h11};
        repeat (4) cycle();
        #1 check("t3_burst_done", 32'(busy), 32'd0);
        req_valid = 4'b0000;
        cycle();
        check("t3_write_count", 32'(wr_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < wr_log.size(); i++)
            check("t3_write_data", 32'(wr_log[i]), (i == 0) ? 32'haa : (i == 1) ? 32'hbb : 32'hcc);

        // 4: FIFO full for three cycles after beat 2.
        do_reset();
        req_valid = 4'b0001;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h55};
        repeat (2) cycle();
        repeat (3) begin
            f_full = 1'b1;
            #1;
            check("t4_full_grant", 32'(grant), 32'b0001);
            check("t4_full_wr", 32'(WR_EN), 32'd0);
            cycle();
        end
        f_full = 1'b0;
        repeat (2) cycle();
        req_valid = 4'b0000;
        cycle();
        check("t4_write_count", 32'(wr_log.size()), 32'd4);

        // 5: arb_en drops mid-burst; burst finishes, then the port stays idle.
        do_reset();
        req_valid = 4'b1111;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        cycle();
        arb_en = 1'b0;
        repeat (3) cycle();
        repeat (3) cycle();
        #1;
        check("t5_idle_wr", 32'(WR_EN), 32'd0);
        check("t5_idle_grant", 32'(grant), 32'd0);
        check("t5_burst_count", 32'(wr_log.size()), 32'd4);
        wr_log.delete();
        arb_en = 1'b1;
        cycle();
        check("t5_resume_data", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hffff, 32'h22);

        // 6: asynchronous reset pulse in the middle of a cycle.
        do_reset();
        req_valid = 4'b1111;
        repeat (2) cycle();
        #3 asyn_rst = 1'b0;
        #1;
        check("t6_rst_grant", 32'(grant), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_wr", 32'(WR_EN), 32'd0);
        @(negedge clk);
        cycle();
        asyn_rst = 1'b1;
        #1 check("t6_first_ready", 32'(req_ready), 32'b0001);
        cycle();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom_range(0, 15));
            req_data  = $urandom;
            f_full    = ($urandom_range(0, 3) == 0);
            arb_en    = ($urandom_range(0, 7) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
